// File: rtl/up_down_counter_3to12_monitor_if.sv
// rtl/up_down_counter_3to12_monitor_if.sv - counter-side inputs and checker results of the 3..12 counter monitor
interface up_down_counter_3to12_monitor_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             clr;
   logic             up_down;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             armed;
   logic             err;
   logic [1:0]       err_code;
   logic [WIDTH-1:0] err_q;
   logic [WIDTH-1:0] err_exp;
   logic [CNT_W-1:0] wrap_up_cnt;
   logic [CNT_W-1:0] wrap_dn_cnt;

   // Driver side: the counter's nets plus the clear request.
   modport master (
      output clr, up_down, load, d, q,
      input  armed, err, err_code, err_q, err_exp, wrap_up_cnt, wrap_dn_cnt
   );

   // Monitor side.
   modport slave (
      input  clr, up_down, load, d, q,
      output armed, err, err_code, err_q, err_exp, wrap_up_cnt, wrap_dn_cnt
   );
endinterface

// File: rtl/up_down_counter_3to12_monitor.sv
// rtl/up_down_counter_3to12_monitor.sv - predicts each q of a 3..12 up/down counter, flags and captures the first error, counts wraps
module up_down_counter_3to12_monitor #(
   parameter int WIDTH = 4,
   parameter int MIN   = 3,
   parameter int MAX   = 12,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic reset,
   up_down_counter_3to12_monitor_if.slave mon
);
   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   typedef enum logic [1:0] {SYNC, CHECK, HALT} state_t;

   state_t           state;
   logic             armed_r;
   logic             err_r;
   logic [1:0]       err_code_r;
   logic [WIDTH-1:0] err_q_r;
   logic [WIDTH-1:0] err_exp_r;
   logic [CNT_W-1:0] wrap_up_r;
   logic [CNT_W-1:0] wrap_dn_r;

   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] p_d;
   logic             p_ud;
   logic             p_ld;

   logic [WIDTH-1:0] exp_q;
   logic             mism;
   logic             range_err;
   logic             wrap_up;
   logic             wrap_dn;

   // Previous-cycle copy of the counter's inputs and output; the prediction is built from it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_q  <= '0;
         p_d  <= '0;
         p_ud <= 1'b0;
         p_ld <= 1'b0;
      end else begin
         p_q  <= mon.q;
         p_d  <= mon.d;
         p_ud <= mon.up_down;
         p_ld <= mon.load;
      end
   end

   // Expected counter value now, given what the counter saw on the previous edge.
   always_comb begin
      exp_q = p_d;
      if (!p_ld) begin
         if (p_ud) begin
            exp_q = (p_q >= MAX_V) ? MIN_V : p_q + WIDTH'(1);
         end else begin
            exp_q = (p_q <= MIN_V) ? MAX_V : p_q - WIDTH'(1);
         end
      end
   end

   assign mism      = (mon.q != exp_q);
   assign range_err = (mon.q < MIN_V) || (mon.q > MAX_V);
   // A load is never counted as a wrap, even when it lands on the wrap target.
   assign wrap_up   = !p_ld &&  p_ud && (p_q == MAX_V) && (mon.q == MIN_V);
   assign wrap_dn   = !p_ld && !p_ud && (p_q == MIN_V) && (mon.q == MAX_V);

   // Checker FSM: prime history, check every edge, freeze the first failure; clr beats errors and wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= SYNC;
         armed_r    <= 1'b0;
         err_r      <= 1'b0;
         err_code_r <= 2'b00;
         err_q_r    <= '0;
         err_exp_r  <= '0;
         wrap_up_r  <= '0;
         wrap_dn_r  <= '0;
      end else if (mon.clr) begin
         state      <= SYNC;
         armed_r    <= 1'b0;
         err_r      <= 1'b0;
         err_code_r <= 2'b00;
         err_q_r    <= '0;
         err_exp_r  <= '0;
         wrap_up_r  <= '0;
         wrap_dn_r  <= '0;
      end else begin
         if (state != SYNC) begin
            if (wrap_up && (wrap_up_r != '1)) begin
               wrap_up_r <= wrap_up_r + CNT_W'(1);
            end
            if (wrap_dn && (wrap_dn_r != '1)) begin
               wrap_dn_r <= wrap_dn_r + CNT_W'(1);
            end
         end
         case (state)
            SYNC: begin
               state   <= CHECK;
               armed_r <= 1'b1;
            end
            CHECK: begin
               if (mism || range_err) begin
                  state      <= HALT;
                  armed_r    <= 1'b0;
                  err_r      <= 1'b1;
                  err_code_r <= {range_err, mism};
                  err_q_r    <= mon.q;
                  err_exp_r  <= exp_q;
               end
            end
            HALT: begin
               armed_r <= 1'b0;
            end
            default: begin
               state   <= SYNC;
               armed_r <= 1'b0;
            end
         endcase
      end
   end

   assign mon.armed       = armed_r;
   assign mon.err         = err_r;
   assign mon.err_code    = err_code_r;
   assign mon.err_q       = err_q_r;
   assign mon.err_exp     = err_exp_r;
   assign mon.wrap_up_cnt = wrap_up_r;
   assign mon.wrap_dn_cnt = wrap_dn_r;
endmodule

// File: tb/tb_up_down_counter_3to12_monitor.sv
// tb/tb_up_down_counter_3to12_monitor.sv - directed table, random and corner-case bench for the counter monitor
module tb_up_down_counter_3to12_monitor;
   localparam int WIDTH   = 4;
   localparam int MIN     = 3;
   localparam int MAX     = 12;
   localparam int CNT_W   = 8;
   localparam int SAT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   up_down_counter_3to12_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   up_down_counter_3to12_monitor #(
      .WIDTH(WIDTH), .MIN(MIN), .MAX(MAX), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (bus)
   );

   typedef struct {
      bit clr;
      bit ud;
      bit ld;
      int d;
      int q;
      bit armed;
      bit err;
      int code;
      int eq;
      int ee;
      int wu;
      int wd;
   } vec_t;

   vec_t tbl[$];

   int n_vec = 0;
   int n_bad = 0;

   // reference model: previous sample, checker phase and results
   int h_q, h_d;
   bit h_ud, h_ld;
   int m_phase;  // 0 priming, 1 checking, 2 halted
   bit m_err;
   int m_code, m_eq, m_ee, m_wu, m_wd;
   int cnt;      // value the real counter would be showing

   function automatic int next_val(int q, bit ud, bit ld, int d);
      if (ld) return d;
      if (ud) return (q >= MAX) ? MIN : q + 1;
      return (q <= MIN) ? MAX : q - 1;
   endfunction

   function automatic logic [27:0] pack(bit a, bit e, int c, int eq, int ee, int wu, int wd);
      return {a, e, 2'(c), 4'(eq), 4'(ee), 8'(wu), 8'(wd)};
   endfunction

   function automatic logic [27:0] dut_out();
      return {bus.armed, bus.err, bus.err_code, bus.err_q, bus.err_exp,
              bus.wrap_up_cnt, bus.wrap_dn_cnt};
   endfunction

   task automatic check(string name, logic [27:0] exp);
      logic [27:0] got;
      got = dut_out();
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got armed/err/code/eq/ee/wu/wd=%b/%b/%b/%0d/%0d/%0d/%0d required %b/%b/%b/%0d/%0d/%0d/%0d",
                  name, $time, got[27], got[26], got[25:24], got[23:20], got[19:16], got[15:8], got[7:0],
                  exp[27], exp[26], exp[25:24], exp[23:20], exp[19:16], exp[15:8], exp[7:0]);
      end
   endtask

   task automatic model_reset();
      h_q = 0; h_d = 0; h_ud = 0; h_ld = 0;
      m_phase = 0; m_err = 0; m_code = 0; m_eq = 0; m_ee = 0; m_wu = 0; m_wd = 0;
      cnt = MIN;
   endtask

   task automatic model_edge(bit clr, bit ud, bit ld, int d, int q);
      int  e;
      bit  oor;
      e   = next_val(h_q, h_ud, h_ld, h_d);
      oor = (q < MIN) || (q > MAX);
      if (clr) begin
         m_err = 0; m_code = 0; m_eq = 0; m_ee = 0; m_wu = 0; m_wd = 0; m_phase = 0;
      end else begin
         if (m_phase != 0) begin
            if (!h_ld && h_ud && h_q == MAX && q == MIN && m_wu < SAT_MAX) m_wu++;
            if (!h_ld && !h_ud && h_q == MIN && q == MAX && m_wd < SAT_MAX) m_wd++;
         end
         if (m_phase == 0) begin
            m_phase = 1;
         end else if (m_phase == 1 && (oor || q != e)) begin
            m_err   = 1;
            m_code  = (oor ? 2 : 0) + ((q != e) ? 1 : 0);
            m_eq    = q;
            m_ee    = e;
            m_phase = 2;
         end
      end
      h_q = q; h_d = d; h_ud = ud; h_ld = ld;
   endtask

   // Called at a falling edge: drive, clock, update models, compare, return at the next falling edge.
   task automatic apply(bit clr, bit ud, bit ld, int d, int q);
      bus.clr     = clr;
      bus.up_down = ud;
      bus.load    = ld;
      bus.d       = WIDTH'(d);
      bus.q       = WIDTH'(q);
      @(posedge clk);
      model_edge(clr, ud, ld, d, q);
      cnt = next_val(cnt, ud, ld, d);
      #1;
      check("model", pack(m_phase == 1, m_err, m_code, m_eq, m_ee, m_wu, m_wd));
      @(negedge clk);
   endtask

   task automatic add(bit clr, bit ud, bit ld, int d, int q,
                      bit armed, bit err, int code, int eq, int ee, int wu, int wd);
      vec_t v;
      v.clr = clr; v.ud = ud; v.ld = ld; v.d = d; v.q = q;
      v.armed = armed; v.err = err; v.code = code; v.eq = eq; v.ee = ee; v.wu = wu; v.wd = wd;
      tbl.push_back(v);
   endtask

   initial begin
      // count up through a full lap and one up-wrap
      add(0, 1, 0, 0, 3,   1, 0, 0, 0, 0, 0, 0);
      for (int q = 4; q <= 12; q++) add(0, 1, 0, 0, q, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 3,   1, 0, 0, 0, 0, 1, 0);
      // count down: two down-wraps
      add(0, 0, 0, 0, 12,  1, 0, 0, 0, 0, 1, 1);
      for (int q = 11; q >= 3; q--) add(0, 0, 0, 0, q, 1, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 12,  1, 0, 0, 0, 0, 1, 2);
      // load 7 then count up: no wrap, no error
      add(0, 1, 1, 7, 11,  1, 0, 0, 0, 0, 1, 2);
      add(0, 1, 0, 0, 7,   1, 0, 0, 0, 0, 1, 2);
      add(0, 1, 0, 0, 8,   1, 0, 0, 0, 0, 1, 2);
      add(0, 1, 0, 0, 9,   1, 0, 0, 0, 0, 1, 2);
      add(0, 0, 0, 0, 10,  1, 0, 0, 0, 0, 1, 2);
      add(0, 0, 0, 0, 9,   1, 0, 0, 0, 0, 1, 2);
      // q=9 where 8 is expected; a later fault must not overwrite the capture
      add(0, 0, 0, 0, 9,   0, 1, 1, 9, 8, 1, 2);
      add(0, 0, 0, 0, 0,   0, 1, 1, 9, 8, 1, 2);
      // clr, re-arm, load of out-of-range 14
      add(1, 1, 0, 0, 6,   0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 7,   1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 14, 8,  1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 14,  0, 1, 2, 14, 14, 0, 0);
      add(1, 1, 0, 0, 3,   0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 4,   1, 0, 0, 0, 0, 0, 0);

      reset = 1'b1;
      bus.clr = 0; bus.up_down = 0; bus.load = 0; bus.d = '0; bus.q = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("reset_state", pack(0, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;

      foreach (tbl[i]) begin
         apply(tbl[i].clr, tbl[i].ud, tbl[i].ld, tbl[i].d, tbl[i].q);
         check($sformatf("table_row%0d", i),
               pack(tbl[i].armed, tbl[i].err, tbl[i].code, tbl[i].eq, tbl[i].ee, tbl[i].wu, tbl[i].wd));
      end

      // random traffic: real counter behaviour with occasional faults, clears and loads
      for (int i = 0; i < 400; i++) begin
         bit c, u, l;
         int dv, qv;
         c  = ($urandom_range(0, 39) == 0);
         u  = $urandom_range(0, 1);
         l  = ($urandom_range(0, 7) == 0);
         dv = $urandom_range(0, 15);
         qv = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 15)) : cnt;
         apply(c, u, l, dv, qv);
      end

      // asynchronous reset between edges after an error
      apply(1, 1, 0, 0, cnt);
      apply(0, 1, 0, 0, cnt);
      apply(0, 1, 0, 0, (cnt + 5) % 16);
      check("err_before_reset", pack(0, 1, m_code, m_eq, m_ee, m_wu, m_wd));
      #2 reset = 1'b1;
      #1;
      check("async_reset", pack(0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      model_reset();
      reset = 1'b0;

      // 300+ up-wraps: wrap_up_cnt saturates at all-ones
      for (int i = 0; i < 3010; i++) apply(0, 1, 0, 0, cnt);
      check("wrap_up_saturated", pack(1, 0, 0, 0, 0, SAT_MAX, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
